pe_net_interface: RTL and testbench
===================================

// Module: pe_net_interface
// PURPOSE
// PE-side endpoint of the Hoplite 3D router PE ports. TX path queues PE flits and
// drives router injection with hold-and-retry on injection_success. RX path absorbs
// up to three ejected flits per cycle (x/y/z) into one FIFO and serialises them to
// the PE via valid/ready. Flits are opaque; routing fields are already in the flit.
// PARAMETERS
// FLIT_SIZE  128  flit width in bits
// TX_DEPTH   4    TX FIFO entries, power of 2, >=2
// RX_DEPTH   8    RX FIFO entries, power of 2, >=4
// CNT_WIDTH  16   width of statistics counters (NIC_STATS_EN only)
// PORTS
// clk                in   1          clock
// rst                in   1          synchronous active-high reset
// tx_valid           in   1          PE offers flit
// tx_flit            in   FLIT_SIZE  PE flit
// tx_ready           out  1          TX FIFO not full
// pe_in_valid        out  1          injection request to router
// pe_input           out  FLIT_SIZE  flit offered to router = TX FIFO head
// injection_success  in   1          router ack, registered, 1 cycle after offer
// x/y/z_eject        in   FLIT_SIZE  ejected flits from router
// x/y/z_eject_valid  in   1          eject valids
// rx_valid           out  1          RX FIFO not empty
// rx_flit            out  FLIT_SIZE  RX FIFO head
// rx_ready           in   1          PE accepts rx_flit
// rx_overflow        out  1          sticky: an ejected flit was dropped
// BEHAVIOUR
// - Reset: both FIFOs empty, TX FSM=IDLE, pe_in_valid=0, pe_input=0, tx_ready=0 during
//   rst then 1, rx_valid=0, rx_flit=0, rx_overflow=0, all counters 0.
// - TX push: tx_valid&&tx_ready. tx_ready=(tx_count!=TX_DEPTH); no push-when-full bypass.
// - TX FSM (pe_in_valid = state==OFFER, pe_input = head when non-empty else 0):
//   IDLE: -> OFFER when TX FIFO non-empty (flit pushed in cycle t offered in t+1).
//   OFFER: pe_in_valid=1 exactly this cycle -> WAIT unconditionally.
//   WAIT: pe_in_valid=0; sample injection_success. 1: pop head, -> OFFER if more
//   entries remain after pop (incl. same-cycle push) else IDLE. 0: -> OFFER (retry).
// - Never two consecutive pe_in_valid cycles: router cannot double-inject. Max TX rate
//   1 flit / 2 cycles. injection_success outside WAIT is ignored.
// - pe_input held stable from OFFER through WAIT and across all retries.
// - RX write: in one cycle, valid ejects written in order x, y, z to consecutive slots.
//   free = RX_DEPTH - rx_count at cycle start; a same-cycle pop does NOT add space.
//   If valids > free: accept first `free` in x,y,z order, drop rest, set rx_overflow
//   (sticky until rst). Ejection cannot be back-pressured.
// - RX read: rx_valid=(rx_count!=0); pop on rx_valid&&rx_ready. Eject at edge e
//   -> rx_valid at e+1 (1-cycle latency). Pointers wrap mod RX_DEPTH;
//   rx_count width clog2(RX_DEPTH)+1.
// - Reset mid-operation (incl. mid-retry): in-flight TX flit and all queued data
//   discarded; a late injection_success after reset is ignored (FSM in IDLE).
// CONFIGURATION
// NIC_STATS_EN defined: adds outputs tx_sent_cnt, tx_retry_cnt, rx_recv_cnt,
//   rx_drop_cnt (CNT_WIDTH each, saturating, reset 0); sent++ on WAIT&&success,
//   retry++ on WAIT&&!success, recv += accepted ejects, drop += dropped ejects.
// Undefined: ports and counters absent; all other behaviour identical.
// TESTING
// 1 Hold rst 3 cycles, toggle all inputs -> all outputs at reset values listed.
// 2 Push tx_flit=0xA5 at t, success=1 at t+2 -> pe_in_valid only at t+1, pop at t+2,
//   FSM IDLE at t+3.
// 3 Push 0x11; success=0,0,1 -> pe_in_valid at t+1,t+3,t+5, pe_input=0x11 throughout;
//   tx_retry_cnt=2 with NIC_STATS_EN.
// 4 Eject x=1,y=2,z=3 same cycle, rx_ready=1 -> rx_flit 1,2,3 on consecutive cycles.
// 5 RX_DEPTH=8, rx_ready=0, 3 ejects/cycle x3 -> 8 stored, third-cycle z dropped,
//   rx_overflow=1, rx_drop_cnt=1.
// 6 rst asserted in WAIT with success=1 -> no pop effect, TX FIFO empty, pe_in_valid=0.

Source files
------------

// File: rtl/pe_net_interface.sv
// PE-side network interface for the Hoplite 3D router: TX queue with hold-and-retry
// injection, RX queue absorbing up to three ejects per cycle. Optional stats: NIC_STATS_EN.
module pe_net_interface #(
    parameter int FLIT_SIZE = 128,
    parameter int TX_DEPTH  = 4,
    parameter int RX_DEPTH  = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [FLIT_SIZE-1:0] tx_flit,
    output logic                 tx_ready,
    output logic                 pe_in_valid,
    output logic [FLIT_SIZE-1:0] pe_input,
    input  logic                 injection_success,
    input  logic [FLIT_SIZE-1:0] x_eject,
    input  logic [FLIT_SIZE-1:0] y_eject,
    input  logic [FLIT_SIZE-1:0] z_eject,
    input  logic                 x_eject_valid,
    input  logic                 y_eject_valid,
    input  logic                 z_eject_valid,
    output logic                 rx_valid,
    output logic [FLIT_SIZE-1:0] rx_flit,
    input  logic                 rx_ready,
    output logic                 rx_overflow
`ifdef NIC_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] tx_sent_cnt,
    output logic [CNT_WIDTH-1:0] tx_retry_cnt,
    output logic [CNT_WIDTH-1:0] rx_recv_cnt,
    output logic [CNT_WIDTH-1:0] rx_drop_cnt
`endif
);

    localparam int TA_W = $clog2(TX_DEPTH);
    localparam int RA_W = $clog2(RX_DEPTH);
    localparam logic [TA_W:0] TX_FULL = (TA_W + 1)'(TX_DEPTH);
    localparam logic [RA_W:0] RX_FULL = (RA_W + 1)'(RX_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        WAIT  = 2'd2
    } tx_state_t;

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                     input logic [1:0]           inc);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, cnt} + {{(CNT_WIDTH - 1){1'b0}}, inc};
        return sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
    endfunction

    // TX state
    logic [FLIT_SIZE-1:0] tx_mem_q [TX_DEPTH];
    logic [TA_W-1:0]      tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [TA_W:0]        tx_count_q, tx_count_d;
    tx_state_t            tx_state_q, tx_state_d;
    logic                 tx_push, tx_pop;

    // RX state
    logic [FLIT_SIZE-1:0] rx_mem_q [RX_DEPTH];
    logic [RA_W-1:0]      rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [RA_W:0]        rx_count_q, rx_count_d;
    logic                 rx_overflow_q, rx_overflow_d;
    logic [RA_W:0]        rx_free;
    logic [1:0]           rx_acc, rx_drop;
    logic                 rx_pop;
    logic [2:0]           rx_we;
    logic [RA_W-1:0]      rx_waddr [3];
    logic [FLIT_SIZE-1:0] ej_data  [3];
    logic [2:0]           ej_valid;

    always_comb begin
        tx_push    = tx_valid && (tx_count_q != TX_FULL);
        tx_pop     = (tx_state_q == WAIT) && injection_success;
        tx_wr_d    = tx_wr_q + TA_W'(tx_push);
        tx_rd_d    = tx_rd_q + TA_W'(tx_pop);
        tx_count_d = tx_count_q + (TA_W + 1)'(tx_push) - (TA_W + 1)'(tx_pop);
        tx_state_d = tx_state_q;
        // One offer per two cycles: the router sees a single-cycle request, then we wait for its ack.
        case (tx_state_q)
            IDLE:    if ((tx_count_q != '0) || tx_push) tx_state_d = OFFER;
            OFFER:   tx_state_d = WAIT;
            WAIT: begin
                if (injection_success) tx_state_d = (tx_count_d != '0) ? OFFER : IDLE;
                else                   tx_state_d = OFFER;
            end
            default: tx_state_d = IDLE;
        endcase
    end

    assign tx_ready    = !rst && (tx_count_q != TX_FULL);
    assign pe_in_valid = (tx_state_q == OFFER);
    assign pe_input    = (tx_count_q != '0) ? tx_mem_q[tx_rd_q] : '0;

    always_comb begin
        ej_data[0] = x_eject;
        ej_data[1] = y_eject;
        ej_data[2] = z_eject;
        ej_valid   = {z_eject_valid, y_eject_valid, x_eject_valid};
        // Space is judged at cycle start; a pop in this same cycle does not make room.
        rx_free    = RX_FULL - rx_count_q;
        rx_acc     = 2'd0;
        rx_drop    = 2'd0;
        for (int i = 0; i < 3; i++) begin
            rx_we[i]    = 1'b0;
            rx_waddr[i] = rx_wr_q;
            if (ej_valid[i]) begin
                if ((RA_W + 1)'(rx_acc) < rx_free) begin
                    rx_we[i]    = 1'b1;
                    rx_waddr[i] = rx_wr_q + RA_W'(rx_acc);
                    rx_acc      = rx_acc + 2'd1;
                end else begin
                    rx_drop = rx_drop + 2'd1;
                end
            end
        end
        rx_pop        = (rx_count_q != '0) && rx_ready;
        rx_wr_d       = rx_wr_q + RA_W'(rx_acc);
        rx_rd_d       = rx_rd_q + RA_W'(rx_pop);
        rx_count_d    = rx_count_q + (RA_W + 1)'(rx_acc) - (RA_W + 1)'(rx_pop);
        rx_overflow_d = rx_overflow_q || (rx_drop != 2'd0);
    end

    assign rx_valid    = (rx_count_q != '0);
    assign rx_flit     = rx_valid ? rx_mem_q[rx_rd_q] : '0;
    assign rx_overflow = rx_overflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr_q       <= '0;
            tx_rd_q       <= '0;
            tx_count_q    <= '0;
            tx_state_q    <= IDLE;
            rx_wr_q       <= '0;
            rx_rd_q       <= '0;
            rx_count_q    <= '0;
            rx_overflow_q <= 1'b0;
        end else begin
            tx_wr_q       <= tx_wr_d;
            tx_rd_q       <= tx_rd_d;
            tx_count_q    <= tx_count_d;
            tx_state_q    <= tx_state_d;
            rx_wr_q       <= rx_wr_d;
            rx_rd_q       <= rx_rd_d;
            rx_count_q    <= rx_count_d;
            rx_overflow_q <= rx_overflow_d;
        end
    end

    // Storage arrays carry no reset; the counts above define what is valid.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wr_q] <= tx_flit;
        for (int i = 0; i < 3; i++) begin
            if (rx_we[i]) rx_mem_q[rx_waddr[i]] <= ej_data[i];
        end
    end

`ifdef NIC_STATS_EN
    logic [CNT_WIDTH-1:0] tx_sent_q, tx_sent_d, tx_retry_q, tx_retry_d;
    logic [CNT_WIDTH-1:0] rx_recv_q, rx_recv_d, rx_drop_q, rx_drop_d;

    always_comb begin
        tx_sent_d  = sat_add(tx_sent_q, {1'b0, tx_pop});
        tx_retry_d = sat_add(tx_retry_q, {1'b0, (tx_state_q == WAIT) && !injection_success});
        rx_recv_d  = sat_add(rx_recv_q, rx_acc);
        rx_drop_d  = sat_add(rx_drop_q, rx_drop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_sent_q  <= '0;
            tx_retry_q <= '0;
            rx_recv_q  <= '0;
            rx_drop_q  <= '0;
        end else begin
            tx_sent_q  <= tx_sent_d;
            tx_retry_q <= tx_retry_d;
            rx_recv_q  <= rx_recv_d;
            rx_drop_q  <= rx_drop_d;
        end
    end

    assign tx_sent_cnt  = tx_sent_q;
    assign tx_retry_cnt = tx_retry_q;
    assign rx_recv_cnt  = rx_recv_q;
    assign rx_drop_cnt  = rx_drop_q;
`endif

endmodule

// File: tb/tb_pe_net_interface.sv
// Directed bench for pe_net_interface: per-cycle vector table for reset, TX and RX
// basics, plus hand sequences for RX overflow and reset during a pending injection.
module tb_pe_net_interface;

    localparam int FS = 128;
    localparam int CW = 16;

    logic          clk;
    logic          rst;
    logic          tx_valid;
    logic [FS-1:0] tx_flit;
    logic          tx_ready;
    logic          pe_in_valid;
    logic [FS-1:0] pe_input;
    logic          injection_success;
    logic [FS-1:0] x_eject, y_eject, z_eject;
    logic          x_eject_valid, y_eject_valid, z_eject_valid;
    logic          rx_valid;
    logic [FS-1:0] rx_flit;
    logic          rx_ready;
    logic          rx_overflow;
`ifdef NIC_STATS_EN
    logic [CW-1:0] tx_sent_cnt, tx_retry_cnt, rx_recv_cnt, rx_drop_cnt;
`endif

    pe_net_interface #(
        .FLIT_SIZE(FS), .TX_DEPTH(4), .RX_DEPTH(8), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .tx_valid(tx_valid), .tx_flit(tx_flit), .tx_ready(tx_ready),
        .pe_in_valid(pe_in_valid), .pe_input(pe_input),
        .injection_success(injection_success),
        .x_eject(x_eject), .y_eject(y_eject), .z_eject(z_eject),
        .x_eject_valid(x_eject_valid), .y_eject_valid(y_eject_valid),
        .z_eject_valid(z_eject_valid),
        .rx_valid(rx_valid), .rx_flit(rx_flit), .rx_ready(rx_ready),
        .rx_overflow(rx_overflow)
`ifdef NIC_STATS_EN
        ,
        .tx_sent_cnt(tx_sent_cnt), .tx_retry_cnt(tx_retry_cnt),
        .rx_recv_cnt(rx_recv_cnt), .rx_drop_cnt(rx_drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       txv;
        logic [7:0] txf;
        logic       succ;
        logic [2:0] ev;
        logic [7:0] ex, ey, ez;
        logic       rr;
        logic       e_piv;
        logic [7:0] e_pin;
        logic       e_trdy;
        logic       e_rv;
        logic [7:0] e_rf;
        logic       e_ovf;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic add(input logic r, input logic tv, input logic [7:0] tf, input logic s,
                       input logic [2:0] ev, input logic [7:0] ex, input logic [7:0] ey,
                       input logic [7:0] ez, input logic rr, input logic piv,
                       input logic [7:0] pin, input logic trdy, input logic rv,
                       input logic [7:0] rf, input logic ovf);
        vec_t v;
        v.rst = r; v.txv = tv; v.txf = tf; v.succ = s; v.ev = ev;
        v.ex = ex; v.ey = ey; v.ez = ez; v.rr = rr;
        v.e_piv = piv; v.e_pin = pin; v.e_trdy = trdy; v.e_rv = rv; v.e_rf = rf; v.e_ovf = ovf;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [FS-1:0] act, input logic [FS-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic tv, input logic [7:0] tf, input logic s,
                         input logic [2:0] ev, input logic [7:0] ex, input logic [7:0] ey,
                         input logic [7:0] ez, input logic rr);
        rst = r; tx_valid = tv; tx_flit = FS'(tf); injection_success = s;
        x_eject_valid = ev[0]; y_eject_valid = ev[1]; z_eject_valid = ev[2];
        x_eject = FS'(ex); y_eject = FS'(ey); z_eject = FS'(ez); rx_ready = rr;
    endtask

    task automatic idle_cycle(input logic rr);
        @(negedge clk);
        drive(0, 0, 8'h00, 0, 3'b000, 8'h00, 8'h00, 8'h00, rr);
        #1;
    endtask

    initial begin
        drive(1, 0, 8'h00, 0, 3'b000, 8'h00, 8'h00, 8'h00, 0);

        // Reset held with inputs toggling
        add(1,1,8'hFF,1,3'b111,8'h09,8'h09,8'h09,1, 0,8'h00,0,0,8'h00,0);
        add(1,0,8'h00,0,3'b000,8'h00,8'h00,8'h00,0, 0,8'h00,0,0,8'h00,0);
        add(1,1,8'hAA,1,3'b001,8'h07,8'h00,8'h00,1, 0,8'h00,0,0,8'h00,0);
        add(0,0,8'h00,0,3'b000,8'h00,8'h00,8'h00,0, 0,8'h00,1,0,8'h00,0);
        // Single flit, immediate success
        add(0,1,8'hA5,0,3'b000,8'h00,8'h00,8'h00,0, 0,8'h00,1,0,8'h00,0);
        add(0,0,8'h00,0,3'b000,8'h00,8'h00,8'h00,0, 1,8'hA5,1,0,8'h00,0);
        add(0,0,8'h00,1,3'b000,8'h00,8'h00,8'h00,0, 0,8'hA5,1,0,8'h00,0);
        add(0,0,8'h00,0,3'b000,8'h00,8'h00,8'h00,0, 0,8'h00,1,0,8'h00,0);
        add(0,0,8'h00,0,3'b000,8'h00,8'h00,8'h00,0, 0,8'h00,1,0,8'h00,0);
        // Two retries; success during OFFER must be ignored
        add(0,1,8'h11,0,3'b000,8'h00,8'h00,8'h00,0, 0,8'h00,1,0,8'h00,0);
        add(0,0,8'h00,0,3'b000,8'h00,8'h00,8'h00,0, 1,8'h11,1,0,8'h00,0);
        add(0,0,8'h00,0,3'b000,8'h00,8'h00,8'h00,0, 0,8'h11,1,0,8'h00,0);
        add(0,0,8'h00,1,3'b000,8'h00,8'h00,8'h00,0, 1,8'h11,1,0,8'h00,0);
        add(0,0,8'h00,0,3'b000,8'h00,8'h00,8'h00,0, 0,8'h11,1,0,8'h00,0);
        add(0,0,8'h00,0,3'b000,8'h00,8'h00,8'h00,0, 1,8'h11,1,0,8'h00,0);
        add(0,0,8'h00,1,3'b000,8'h00,8'h00,8'h00,0, 0,8'h11,1,0,8'h00,0);
        add(0,0,8'h00,0,3'b000,8'h00,8'h00,8'h00,0, 0,8'h00,1,0,8'h00,0);
        // Three ejects in one cycle, serialised x,y,z
        add(0,0,8'h00,0,3'b111,8'h01,8'h02,8'h03,1, 0,8'h00,1,0,8'h00,0);
        add(0,0,8'h00,0,3'b000,8'h00,8'h00,8'h00,1, 0,8'h00,1,1,8'h01,0);
        add(0,0,8'h00,0,3'b000,8'h00,8'h00,8'h00,1, 0,8'h00,1,1,8'h02,0);
        add(0,0,8'h00,0,3'b000,8'h00,8'h00,8'h00,1, 0,8'h00,1,1,8'h03,0);
        add(0,0,8'h00,0,3'b000,8'h00,8'h00,8'h00,1, 0,8'h00,1,0,8'h00,0);
        // Fill TX FIFO, refused push when full, drain in order, push during last pop
        add(0,1,8'h21,0,3'b000,8'h00,8'h00,8'h00,0, 0,8'h00,1,0,8'h00,0);
        add(0,1,8'h22,0,3'b000,8'h00,8'h00,8'h00,0, 1,8'h21,1,0,8'h00,0);
        add(0,1,8'h23,0,3'b000,8'h00,8'h00,8'h00,0, 0,8'h21,1,0,8'h00,0);
        add(0,1,8'h24,0,3'b000,8'h00,8'h00,8'h00,0, 1,8'h21,1,0,8'h00,0);
        add(0,1,8'h25,1,3'b000,8'h00,8'h00,8'h00,0, 0,8'h21,0,0,8'h00,0);
        add(0,0,8'h00,0,3'b000,8'h00,8'h00,8'h00,0, 1,8'h22,1,0,8'h00,0);
        add(0,0,8'h00,1,3'b000,8'h00,8'h00,8'h00,0, 0,8'h22,1,0,8'h00,0);
        add(0,0,8'h00,0,3'b000,8'h00,8'h00,8'h00,0, 1,8'h23,1,0,8'h00,0);
        add(0,0,8'h00,1,3'b000,8'h00,8'h00,8'h00,0, 0,8'h23,1,0,8'h00,0);
        add(0,0,8'h00,0,3'b000,8'h00,8'h00,8'h00,0, 1,8'h24,1,0,8'h00,0);
        add(0,1,8'h26,1,3'b000,8'h00,8'h00,8'h00,0, 0,8'h24,1,0,8'h00,0);
        add(0,0,8'h00,0,3'b000,8'h00,8'h00,8'h00,0, 1,8'h26,1,0,8'h00,0);
        add(0,0,8'h00,1,3'b000,8'h00,8'h00,8'h00,0, 0,8'h26,1,0,8'h00,0);
        add(0,0,8'h00,0,3'b000,8'h00,8'h00,8'h00,0, 0,8'h00,1,0,8'h00,0);

        @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].txv, tbl[i].txf, tbl[i].succ, tbl[i].ev,
                  tbl[i].ex, tbl[i].ey, tbl[i].ez, tbl[i].rr);
            #1;
            chk($sformatf("v%0d pe_in_valid", i), FS'(pe_in_valid), FS'(tbl[i].e_piv));
            chk($sformatf("v%0d pe_input", i),    pe_input,         FS'(tbl[i].e_pin));
            chk($sformatf("v%0d tx_ready", i),    FS'(tx_ready),    FS'(tbl[i].e_trdy));
            chk($sformatf("v%0d rx_valid", i),    FS'(rx_valid),    FS'(tbl[i].e_rv));
            chk($sformatf("v%0d rx_flit", i),     rx_flit,          FS'(tbl[i].e_rf));
            chk($sformatf("v%0d rx_overflow", i), FS'(rx_overflow), FS'(tbl[i].e_ovf));
        end
`ifdef NIC_STATS_EN
        chk("tx_sent_cnt after table",  FS'(tx_sent_cnt),  FS'(7));
        chk("tx_retry_cnt after table", FS'(tx_retry_cnt), FS'(3));
        chk("rx_recv_cnt after table",  FS'(rx_recv_cnt),  FS'(3));
`endif

        // RX overflow: three full eject cycles into an 8-deep FIFO with the PE stalled
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(0, 0, 8'h00, 0, 3'b111, 8'(8'h31 + 3 * c), 8'(8'h32 + 3 * c),
                  8'(8'h33 + 3 * c), 0);
            #1;
            chk($sformatf("ovf clear before fill cycle %0d", c), FS'(rx_overflow), FS'(0));
        end
        idle_cycle(0);
        chk("rx_overflow set", FS'(rx_overflow), FS'(1));
        chk("rx_valid full",   FS'(rx_valid),    FS'(1));
        chk("rx_flit head",    rx_flit,          FS'(8'h31));
`ifdef NIC_STATS_EN
        chk("rx_drop_cnt one",  FS'(rx_drop_cnt), FS'(1));
        chk("rx_recv_cnt full", FS'(rx_recv_cnt), FS'(11));
`endif
        // Full FIFO: a same-cycle pop must not make room for a new eject
        @(negedge clk);
        drive(0, 0, 8'h00, 0, 3'b001, 8'h40, 8'h00, 8'h00, 1);
        #1;
        chk("rx_flit drain 0", rx_flit, FS'(8'h31));
        for (int k = 1; k < 8; k++) begin
            idle_cycle(1);
            chk($sformatf("rx_flit drain %0d", k), rx_flit, FS'(8'(8'h31 + k)));
        end
        idle_cycle(1);
        chk("rx_valid after drain", FS'(rx_valid),    FS'(0));
        chk("rx_overflow sticky",   FS'(rx_overflow), FS'(1));
`ifdef NIC_STATS_EN
        chk("rx_drop_cnt two", FS'(rx_drop_cnt), FS'(2));
`endif

        // Reset while WAIT with success asserted, then a late success
        @(negedge clk);
        drive(0, 1, 8'h66, 0, 3'b001, 8'h50, 8'h00, 8'h00, 0);
        #1;
        @(negedge clk);
        drive(0, 0, 8'h00, 0, 3'b000, 8'h00, 8'h00, 8'h00, 0);
        #1;
        chk("rst seq offer", FS'(pe_in_valid), FS'(1));
        chk("rst seq input", pe_input, FS'(8'h66));
        @(negedge clk);
        drive(1, 0, 8'h00, 1, 3'b000, 8'h00, 8'h00, 8'h00, 0);
        #1;
        chk("tx_ready in rst", FS'(tx_ready), FS'(0));
        @(negedge clk);
        drive(0, 0, 8'h00, 1, 3'b000, 8'h00, 8'h00, 8'h00, 0);
        #1;
        chk("post-rst pe_in_valid", FS'(pe_in_valid), FS'(0));
        chk("post-rst pe_input",    pe_input,         FS'(0));
        chk("post-rst tx_ready",    FS'(tx_ready),    FS'(1));
        chk("post-rst rx_valid",    FS'(rx_valid),    FS'(0));
        chk("post-rst rx_overflow", FS'(rx_overflow), FS'(0));
`ifdef NIC_STATS_EN
        chk("post-rst tx_sent_cnt", FS'(tx_sent_cnt), FS'(0));
        chk("post-rst rx_drop_cnt", FS'(rx_drop_cnt), FS'(0));
`endif
        idle_cycle(0);
        chk("late success ignored valid", FS'(pe_in_valid), FS'(0));
        chk("late success ignored input", pe_input,         FS'(0));
        idle_cycle(0);
        chk("still idle", FS'(pe_in_valid), FS'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
